// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module   : id_stage_pipe
// Brief    : MIPS-style decode stage with a register file and a registered
//            ID/EX pipeline stage. Optional macro ID_WB_BYPASS_EN enables
//            forwarding of a same-cycle write-back to the operand reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_SIZE      = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter bit R0_ZERO       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_WIDTH-1:0]    ir,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [WORD_WIDTH-1:0]    wrt_dt,
  input  logic [REGADDR_WIDTH-1:0] wrt_reg,
  input  logic                     reg_wrt,
  output logic [WORD_WIDTH-1:0]    read_data1,
  output logic [WORD_WIDTH-1:0]    read_data2,
  output logic [WORD_WIDTH-1:0]    offset,
  output logic [REGADDR_WIDTH-1:0] rt,
  output logic [REGADDR_WIDTH-1:0] rd,
  output logic [5:0]               opcode,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic                     out_valid
);

  localparam logic [REGADDR_WIDTH:0] c_reg_size = (REGADDR_WIDTH+1)'(REG_SIZE);

  logic [WORD_WIDTH-1:0]    r_regs [REG_SIZE];

  logic [REGADDR_WIDTH-1:0] w_rs;
  logic [REGADDR_WIDTH-1:0] w_rt;
  logic [REGADDR_WIDTH-1:0] w_rd;
  logic [WORD_WIDTH-1:0]    w_offset;
  logic                     w_wr_en;
  logic                     w_rs_ok;
  logic                     w_rt_ok;
  logic [WORD_WIDTH-1:0]    w_rd1;
  logic [WORD_WIDTH-1:0]    w_rd2;

  assign w_rs     = REGADDR_WIDTH'(ir[25:21]);
  assign w_rt     = REGADDR_WIDTH'(ir[20:16]);
  assign w_rd     = REGADDR_WIDTH'(ir[15:11]);
  assign w_offset = {{(WORD_WIDTH-16){ir[15]}}, ir[15:0]};

  // An index is readable/writable only if in range and not the hardwired zero.
  assign w_wr_en = reg_wrt && ({1'b0, wrt_reg} < c_reg_size)
                   && !(R0_ZERO && (wrt_reg == '0));
  assign w_rs_ok = ({1'b0, w_rs} < c_reg_size) && !(R0_ZERO && (w_rs == '0));
  assign w_rt_ok = ({1'b0, w_rt} < c_reg_size) && !(R0_ZERO && (w_rt == '0));

  always_comb begin
    w_rd1 = '0;
    if (w_rs_ok) begin
      w_rd1 = r_regs[w_rs];
`ifdef ID_WB_BYPASS_EN
      if (w_wr_en && (wrt_reg == w_rs)) w_rd1 = wrt_dt;
`endif
    end
  end

  always_comb begin
    w_rd2 = '0;
    if (w_rt_ok) begin
      w_rd2 = r_regs[w_rt];
`ifdef ID_WB_BYPASS_EN
      if (w_wr_en && (wrt_reg == w_rt)) w_rd2 = wrt_dt;
`endif
    end
  end

  // Register file: writes are independent of stall/flush; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wrt_reg] <= wrt_dt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      read_data1 <= '0;
      read_data2 <= '0;
      offset     <= '0;
      rt         <= '0;
      rd         <= '0;
      opcode     <= '0;
      shamt      <= '0;
      funct      <= '0;
      out_valid  <= 1'b0;
    end else if (!stall) begin
      read_data1 <= w_rd1;
      read_data2 <= w_rd2;
      offset     <= w_offset;
      rt         <= w_rt;
      rd         <= w_rd;
      opcode     <= ir[31:26];
      shamt      <= ir[10:6];
      funct      <= ir[5:0];
      out_valid  <= in_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module   : tb_id_stage_pipe
// Brief    : Randomised scoreboard bench for id_stage_pipe with directed cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wrt_dt = '0;
  logic [4:0]  wrt_reg = '0;
  logic        reg_wrt = 1'b0;
  logic [31:0] read_data1, read_data2, offset;
  logic [4:0]  rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic        out_valid;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .ir(ir), .in_valid(in_valid), .stall(stall),
    .flush(flush), .wrt_dt(wrt_dt), .wrt_reg(wrt_reg), .reg_wrt(reg_wrt),
    .read_data1(read_data1), .read_data2(read_data2), .offset(offset),
    .rt(rt), .rd(rd), .opcode(opcode), .shamt(shamt), .funct(funct),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, off;
    logic [4:0]  rt, rd, sh;
    logic [5:0]  op, fn;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] mreg [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return mreg[idx];
  endfunction

  // Drive one cycle (called just after a falling edge), predict, advance.
  task automatic step(input logic r, input logic f, input logic s, input logic iv,
                      input logic [31:0] instr, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    rst = r; flush = f; stall = s; in_valid = iv; ir = instr;
    reg_wrt = we; wrt_reg = wr; wrt_dt = wd;
    if (r || f) begin
      cur = '{default: '0};
    end else if (!s) begin
      cur.rd1 = mread(instr[25:21], we, wr, wd);
      cur.rd2 = mread(instr[20:16], we, wr, wd);
      cur.off = {{16{instr[15]}}, instr[15:0]};
      cur.op  = instr[31:26];
      cur.rt  = instr[20:16];
      cur.rd  = instr[15:11];
      cur.sh  = instr[10:6];
      cur.fn  = instr[5:0];
      cur.v   = iv;
    end
    if (r) begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else if (we && wr != 0) begin
      mreg[wr] = wd;
    end
    sb.push_back(cur);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a new ID/EX state each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("read_data1", read_data1, e.rd1);
      chk("read_data2", read_data2, e.rd2);
      chk("offset", offset, e.off);
      chk("rt", {27'b0, rt}, {27'b0, e.rt});
      chk("rd", {27'b0, rd}, {27'b0, e.rd});
      chk("opcode", {26'b0, opcode}, {26'b0, e.op});
      chk("shamt", {27'b0, shamt}, {27'b0, e.sh});
      chk("funct", {26'b0, funct}, {26'b0, e.fn});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e.v});
    end
  end

  initial begin
    logic [31:0] a_ir;
    logic [31:0] exp_byp;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    cur = '{default: '0};
    @(negedge clk); #1;
    step(1, 0, 0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 0, 0);

    // Reset after writes clears outputs and the register file.
    step(0, 0, 0, 1, 32'h0000_0000, 1, 5'd5, 32'h55);
    step(1, 0, 0, 1, 32'h00A0_0000, 1, 5'd6, 32'h66);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_read_data1", read_data1, 32'h0);
    step(0, 0, 0, 1, 32'h00A6_0000, 0, 0, 0);
    chk("r5_after_rst", read_data1, 32'h0);
    chk("r6_after_rst", read_data2, 32'h0);

    // lw decode
    step(0, 0, 0, 0, 32'h0, 1, 5'd3, 32'h0000_00AA);
    step(0, 0, 0, 1, 32'h8C62_FFF0, 0, 0, 0);
    chk("lw_rd1", read_data1, 32'h0000_00AA);
    chk("lw_offset", offset, 32'hFFFF_FFF0);
    chk("lw_opcode", {26'b0, opcode}, 32'h23);
    chk("lw_rt", {27'b0, rt}, 32'h2);
    chk("lw_valid", {31'b0, out_valid}, 32'h1);

    // Same-cycle write/read of r4
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h0;
`endif
    step(0, 0, 0, 1, 32'h0080_0000, 1, 5'd4, 32'h1234);
    chk("wb_same_cycle", read_data1, exp_byp);

    // r0 is hardwired
    step(0, 0, 0, 1, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 32'h0000_0000, 1, 5'd0, 32'hFFFF_FFFF);
    chk("r0_zero", read_data1, 32'h0);

    // Stall holds instruction A; stall+flush squashes
    a_ir = 32'h8C62_1234;
    step(0, 0, 0, 1, a_ir, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h0123_8765 + i, 0, 0, 0);
    chk("stall_offset", offset, 32'h0000_1234);
    chk("stall_rd1", read_data1, 32'h0000_00AA);
    step(0, 1, 1, 1, 32'h0123_4567, 0, 0, 0);
    chk("stall_flush_valid", {31'b0, out_valid}, 32'h0);

    // Write during stall becomes visible once stall drops
    step(0, 0, 0, 1, 32'h00E0_0000, 0, 0, 0);
    step(0, 0, 1, 1, 32'h00E0_0000, 1, 5'd7, 32'hCAFE_F00D);
    chk("stall_no_refresh", read_data1, 32'h0);
    step(0, 0, 0, 1, 32'h00E0_0000, 0, 0, 0);
    chk("r7_after_stall", read_data1, 32'hCAFE_F00D);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)),
           $urandom);
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
